// File: rtl/sine_window_phase_gen.sv
// sine_window_phase_gen: upstream angle sequencer for the sine-window generator.
// For each Start_i request it emits theta_n = (n+0.5)*pi/N for n = 0..N-1 as
// binary angles (pi = 2^(PW-1)), folded into [0, pi/2], over a valid/ready
// handshake with one angle per accepted transfer.
module sine_window_phase_gen #(
   parameter int LOG2N = 6,
   parameter int PW    = 16
) (
   input  logic             Clk_i,
   input  logic             Rst_i,
   input  logic             Start_i,
   input  logic             Angle_Ready_i,
   output logic [PW-1:0]    Angle_o,
   output logic [LOG2N-1:0] Index_o,
   output logic             Fold_o,
   output logic             Angle_Valid_o,
   output logic             Last_o,
   output logic             Busy_o,
   output logic             Done_o
);

   // The phase step is pi/N and the first sample sits half a step above zero,
   // so the accumulator never lands exactly on pi/2.
   localparam logic [PW-1:0]    STEP     = PW'(1) << (PW - 1 - LOG2N);
   localparam logic [PW-1:0]    HALF     = PW'(1) << (PW - 2 - LOG2N);
   localparam logic [PW-1:0]    PI       = PW'(1) << (PW - 1);
   localparam logic [PW-1:0]    HPI      = PW'(1) << (PW - 2);
   localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     angle_q, angle_d;
   logic              fold_q, fold_d;
   logic [LOG2N-1:0]  idx_q, idx_d;
   logic              valid_q, busy_q, done_q, last_q;
   logic              handshake;

   assign handshake = (state_q == RUN) & Angle_Ready_i;

   // Next phase and index: seed on a start in IDLE, advance on each accepted
   // angle except the last, otherwise hold so stalled outputs stay stable.
   always_comb begin
      acc_d = acc_q;
      idx_d = idx_q;
      if ((state_q == IDLE) && Start_i) begin
         acc_d = HALF;
         idx_d = '0;
      end else if (handshake && (idx_q != LAST_IDX)) begin
         acc_d = acc_q + STEP;
         idx_d = idx_q + 1'b1;
      end
   end

   // Fold the next phase into [0, pi/2] using sin(pi - x) = sin(x); the
   // accumulator stays below pi so the subtraction never underflows.
   always_comb begin
      fold_d  = (acc_d > HPI);
      angle_d = fold_d ? (PI - acc_d) : acc_d;
   end

   // Phase, index and the folded angle are registered together so the
   // presented angle always matches the presented index.
   always_ff @(posedge Clk_i or posedge Rst_i) begin
      if (Rst_i) begin
         acc_q   <= '0;
         idx_q   <= '0;
         angle_q <= '0;
         fold_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         angle_q <= angle_d;
         fold_q  <= fold_d;
      end
   end

   // Window sequencer with registered status outputs; a start outside IDLE is
   // dropped, and DONE always falls back to IDLE after one cycle.
   always_ff @(posedge Clk_i or posedge Rst_i) begin
      if (Rst_i) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               last_q <= 1'b0;
               if (Start_i) begin
                  state_q <= RUN;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               if (handshake) begin
                  if (idx_q == LAST_IDX) begin
                     state_q <= DONE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     last_q  <= 1'b0;
                  end else begin
                     last_q <= (idx_d == LAST_IDX);
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Angle_o       = angle_q;
   assign Index_o       = idx_q;
   assign Fold_o        = fold_q;
   assign Angle_Valid_o = valid_q;
   assign Last_o        = last_q;
   assign Busy_o        = busy_q;
   assign Done_o        = done_q;

endmodule
